// File: rtl/ycr1_wb_mem_arb.sv
// ycr1_wb_mem_arb: shares one Wishbone slave port between the imem (read-only)
// and dmem masters. Requests and responses are both registered, and only one
// slave transaction is outstanding at a time.
// Optional feature: define YCR1_WB_ARB_TIMEOUT_EN to add a slave ack timeout
// counter and a sticky timeout_o flag.
module ycr1_wb_mem_arb #(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned ARB_MODE       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            wb_clk,
    input  logic            wb_rst_n,
    // imem master
    input  logic            wbm_i_stb_i,
    input  logic [AW-1:0]   wbm_i_adr_i,
    input  logic            wbm_i_we_i,
    input  logic [DW/8-1:0] wbm_i_sel_i,
    output logic [DW-1:0]   wbm_i_dat_o,
    output logic            wbm_i_ack_o,
    output logic            wbm_i_err_o,
    // dmem master
    input  logic            wbm_d_stb_i,
    input  logic [AW-1:0]   wbm_d_adr_i,
    input  logic            wbm_d_we_i,
    input  logic [DW-1:0]   wbm_d_dat_i,
    input  logic [DW/8-1:0] wbm_d_sel_i,
    output logic [DW-1:0]   wbm_d_dat_o,
    output logic            wbm_d_ack_o,
    output logic            wbm_d_err_o,
`ifdef YCR1_WB_ARB_TIMEOUT_EN
    output logic            timeout_o,
`endif
    // shared slave
    output logic            wbs_stb_o,
    output logic [AW-1:0]   wbs_adr_o,
    output logic            wbs_we_o,
    output logic [DW-1:0]   wbs_dat_o,
    output logic [DW/8-1:0] wbs_sel_o,
    input  logic [DW-1:0]   wbs_dat_i,
    input  logic            wbs_ack_i,
    input  logic            wbs_err_i
);

    localparam int unsigned SW = DW / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state, state_nxt;
    // Grant/owner encoding: 1 = dmem, 0 = imem
    logic            last_grant, last_grant_nxt;
    logic            owner, owner_nxt;
    logic            grant_d;
    logic            stb_nxt, we_nxt;
    logic [AW-1:0]   adr_nxt;
    logic [DW-1:0]   dat_nxt;
    logic [SW-1:0]   sel_nxt;
    logic [DW-1:0]   i_dat_nxt, d_dat_nxt;
    logic            i_ack_nxt, i_err_nxt, d_ack_nxt, d_err_nxt;

`ifdef YCR1_WB_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            tmo_nxt;
`endif

    // Arbitration: a lone requester wins; on a tie dmem wins in priority mode,
    // otherwise the master that was not granted last.
    always_comb begin
        grant_d = 1'b0;
        if (wbm_d_stb_i && !wbm_i_stb_i) begin
            grant_d = 1'b1;
        end else if (wbm_d_stb_i && wbm_i_stb_i) begin
            grant_d = (ARB_MODE == 1) ? 1'b1 : !last_grant;
        end
    end

    // Next-state and next-register values
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        owner_nxt      = owner;
        stb_nxt        = wbs_stb_o;
        adr_nxt        = wbs_adr_o;
        we_nxt         = wbs_we_o;
        dat_nxt        = wbs_dat_o;
        sel_nxt        = wbs_sel_o;
        i_dat_nxt      = wbm_i_dat_o;
        d_dat_nxt      = wbm_d_dat_o;
        i_ack_nxt      = 1'b0;
        i_err_nxt      = 1'b0;
        d_ack_nxt      = 1'b0;
        d_err_nxt      = 1'b0;
`ifdef YCR1_WB_ARB_TIMEOUT_EN
        cnt_nxt        = cnt;
        tmo_nxt        = timeout_o;
`endif
        case (state)
            ST_IDLE: begin
                if (wbm_i_stb_i || wbm_d_stb_i) begin
                    owner_nxt = grant_d;
                    if (!grant_d && wbm_i_we_i) begin
                        // imem is read-only: answer with an error locally
                        i_err_nxt = 1'b1;
                        i_dat_nxt = '0;
                        state_nxt = ST_RESP;
                    end else begin
                        stb_nxt   = 1'b1;
                        state_nxt = ST_BUSY;
`ifdef YCR1_WB_ARB_TIMEOUT_EN
                        cnt_nxt   = '0;
`endif
                        if (grant_d) begin
                            adr_nxt = wbm_d_adr_i;
                            we_nxt  = wbm_d_we_i;
                            dat_nxt = wbm_d_dat_i;
                            sel_nxt = wbm_d_sel_i;
                        end else begin
                            adr_nxt = wbm_i_adr_i;
                            we_nxt  = 1'b0;
                            dat_nxt = '0;
                            sel_nxt = wbm_i_sel_i;
                        end
                    end
                end
            end
            ST_BUSY: begin
                if (wbs_ack_i || wbs_err_i) begin
                    stb_nxt   = 1'b0;
                    state_nxt = ST_RESP;
                    if (owner) begin
                        d_dat_nxt = wbs_dat_i;
                        d_err_nxt = wbs_err_i;
                        d_ack_nxt = !wbs_err_i;
                    end else begin
                        i_dat_nxt = wbs_dat_i;
                        i_err_nxt = wbs_err_i;
                        i_ack_nxt = !wbs_err_i;
                    end
                end
`ifdef YCR1_WB_ARB_TIMEOUT_EN
                else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    // Slave never answered: abandon the cycle with an error
                    stb_nxt   = 1'b0;
                    state_nxt = ST_RESP;
                    tmo_nxt   = 1'b1;
                    if (owner) begin
                        d_dat_nxt = '0;
                        d_err_nxt = 1'b1;
                    end else begin
                        i_dat_nxt = '0;
                        i_err_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
`endif
            end
            ST_RESP: begin
                last_grant_nxt = owner;
                state_nxt      = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    // Registered request/response datapath
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            wbs_stb_o   <= 1'b0;
            wbs_adr_o   <= '0;
            wbs_we_o    <= 1'b0;
            wbs_dat_o   <= '0;
            wbs_sel_o   <= '0;
            wbm_i_dat_o <= '0;
            wbm_i_ack_o <= 1'b0;
            wbm_i_err_o <= 1'b0;
            wbm_d_dat_o <= '0;
            wbm_d_ack_o <= 1'b0;
            wbm_d_err_o <= 1'b0;
        end else begin
            last_grant  <= last_grant_nxt;
            owner       <= owner_nxt;
            wbs_stb_o   <= stb_nxt;
            wbs_adr_o   <= adr_nxt;
            wbs_we_o    <= we_nxt;
            wbs_dat_o   <= dat_nxt;
            wbs_sel_o   <= sel_nxt;
            wbm_i_dat_o <= i_dat_nxt;
            wbm_i_ack_o <= i_ack_nxt;
            wbm_i_err_o <= i_err_nxt;
            wbm_d_dat_o <= d_dat_nxt;
            wbm_d_ack_o <= d_ack_nxt;
            wbm_d_err_o <= d_err_nxt;
        end
    end

`ifdef YCR1_WB_ARB_TIMEOUT_EN
    // Timeout counter and sticky timeout flag
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            cnt       <= '0;
            timeout_o <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            timeout_o <= tmo_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_ycr1_wb_mem_arb.sv
// Self-checking bench for ycr1_wb_mem_arb with a behavioural arbitration model.
module tb_ycr1_wb_mem_arb;

    parameter int unsigned ARB_MODE = 0;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 8;

    logic          wb_clk, wb_rst_n;
    logic          wbm_i_stb_i, wbm_i_we_i;
    logic [31:0]   wbm_i_adr_i;
    logic [3:0]    wbm_i_sel_i;
    logic [31:0]   wbm_i_dat_o;
    logic          wbm_i_ack_o, wbm_i_err_o;
    logic          wbm_d_stb_i, wbm_d_we_i;
    logic [31:0]   wbm_d_adr_i, wbm_d_dat_i;
    logic [3:0]    wbm_d_sel_i;
    logic [31:0]   wbm_d_dat_o;
    logic          wbm_d_ack_o, wbm_d_err_o;
    logic          wbs_stb_o, wbs_we_o;
    logic [31:0]   wbs_adr_o, wbs_dat_o, wbs_dat_i;
    logic [3:0]    wbs_sel_o;
    logic          wbs_ack_i, wbs_err_i;
`ifdef YCR1_WB_ARB_TIMEOUT_EN
    logic          timeout_o;
`endif

    int checks   = 0;
    int failures = 0;
    // Model: which master was granted most recently (1 = dmem)
    bit last_d   = 1'b1;

    ycr1_wb_mem_arb #(
        .AW(AW), .DW(DW), .ARB_MODE(ARB_MODE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
        .wbm_i_stb_i(wbm_i_stb_i), .wbm_i_adr_i(wbm_i_adr_i), .wbm_i_we_i(wbm_i_we_i),
        .wbm_i_sel_i(wbm_i_sel_i), .wbm_i_dat_o(wbm_i_dat_o), .wbm_i_ack_o(wbm_i_ack_o),
        .wbm_i_err_o(wbm_i_err_o),
        .wbm_d_stb_i(wbm_d_stb_i), .wbm_d_adr_i(wbm_d_adr_i), .wbm_d_we_i(wbm_d_we_i),
        .wbm_d_dat_i(wbm_d_dat_i), .wbm_d_sel_i(wbm_d_sel_i), .wbm_d_dat_o(wbm_d_dat_o),
        .wbm_d_ack_o(wbm_d_ack_o), .wbm_d_err_o(wbm_d_err_o),
`ifdef YCR1_WB_ARB_TIMEOUT_EN
        .timeout_o(timeout_o),
`endif
        .wbs_stb_o(wbs_stb_o), .wbs_adr_o(wbs_adr_o), .wbs_we_o(wbs_we_o),
        .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    function automatic logic [137:0] all_outs();
        return {wbm_i_dat_o, wbm_i_ack_o, wbm_i_err_o, wbm_d_dat_o, wbm_d_ack_o,
                wbm_d_err_o, wbs_stb_o, wbs_adr_o, wbs_we_o, wbs_dat_o, wbs_sel_o};
    endfunction

    // Spec rule: lone requester wins; tie -> dmem in mode 1, else not-last-granted
    function automatic bit model_pick_d();
        if (!wbm_i_stb_i) return 1'b1;
        if (!wbm_d_stb_i) return 1'b0;
        if (ARB_MODE == 1) return 1'b1;
        return !last_d;
    endfunction

    task automatic apply_reset();
        wb_rst_n = 1'b0;
        wbm_i_stb_i = 0; wbm_i_we_i = 0; wbm_i_adr_i = '0; wbm_i_sel_i = '0;
        wbm_d_stb_i = 0; wbm_d_we_i = 0; wbm_d_adr_i = '0; wbm_d_dat_i = '0; wbm_d_sel_i = '0;
        wbs_ack_i = 0; wbs_err_i = 0; wbs_dat_i = '0;
        repeat (3) @(negedge wb_clk);
        wb_rst_n = 1'b1;
        last_d = 1'b1;
        @(negedge wb_clk);
    endtask

    // Serve one arbitration round; requests must already be driven this negedge.
    task automatic do_round(input int wt, input bit serr, input bit sack,
                            input logic [31:0] rdat, output int lat, output bit who_d);
        bit ew, werr, seen;
        logic [68:0] exp_req;
        logic [3:0]  exp_rsp;
        logic [31:0] exp_rd;
        ew   = model_pick_d();
        werr = !ew && wbm_i_we_i;
        exp_req = ew ? {wbm_d_adr_i, wbm_d_we_i, wbm_d_dat_i, wbm_d_sel_i}
                     : {wbm_i_adr_i, 1'b0, 32'h0, wbm_i_sel_i};
        lat = 0; seen = 0;
        if (werr) begin
            for (int n = 0; n < 6 && !seen; n++) begin
                @(negedge wb_clk); lat++;
                checks++;
                if (wbs_stb_o !== 1'b0) begin
                    failures++; $display("FAIL imem_wr_no_slave: wbs_stb_o=%b required 0", wbs_stb_o);
                end
                if (wbm_i_err_o === 1'b1) seen = 1;
            end
            exp_rsp = 4'b0100;
            exp_rd  = '0;
        end else begin
            for (int n = 0; n < 6 && !seen; n++) begin
                @(negedge wb_clk); lat++;
                if (wbs_stb_o === 1'b1) seen = 1;
            end
            checks++;
            if (!seen) begin
                failures++; $display("FAIL slave_req_timeout: wbs_stb_o never rose");
            end
            checks++;
            if ({wbs_adr_o, wbs_we_o, wbs_dat_o, wbs_sel_o} !== exp_req) begin
                failures++; $display("FAIL slave_req: got %h required %h",
                                     {wbs_adr_o, wbs_we_o, wbs_dat_o, wbs_sel_o}, exp_req);
            end
            for (int n = 0; n < wt; n++) begin
                @(negedge wb_clk); lat++;
                checks++;
                if ({wbs_stb_o, wbs_adr_o, wbs_we_o, wbs_dat_o, wbs_sel_o} !== {1'b1, exp_req}) begin
                    failures++; $display("FAIL slave_hold: got %h required %h",
                        {wbs_stb_o, wbs_adr_o, wbs_we_o, wbs_dat_o, wbs_sel_o}, {1'b1, exp_req});
                end
            end
            @(negedge wb_clk); lat++;
            wbs_ack_i = sack; wbs_err_i = serr; wbs_dat_i = rdat;
            @(negedge wb_clk); lat++;
            wbs_ack_i = 0; wbs_err_i = 0; wbs_dat_i = $urandom;
            exp_rsp = ew ? {2'b00, !serr, serr} : {!serr, serr, 2'b00};
            exp_rd  = rdat;
        end
        who_d = wbm_d_ack_o | wbm_d_err_o;
        checks++;
        if ({wbm_i_ack_o, wbm_i_err_o, wbm_d_ack_o, wbm_d_err_o} !== exp_rsp) begin
            failures++; $display("FAIL master_rsp: got %b required %b",
                {wbm_i_ack_o, wbm_i_err_o, wbm_d_ack_o, wbm_d_err_o}, exp_rsp);
        end
        checks++;
        if ((ew ? wbm_d_dat_o : wbm_i_dat_o) !== exp_rd) begin
            failures++; $display("FAIL master_dat: got %h required %h",
                                 ew ? wbm_d_dat_o : wbm_i_dat_o, exp_rd);
        end
        checks++;
        if (wbs_stb_o !== 1'b0) begin
            failures++; $display("FAIL slave_stb_drop: got %b required 0", wbs_stb_o);
        end
        if (ew) wbm_d_stb_i = 0; else wbm_i_stb_i = 0;
        last_d = ew;
        @(negedge wb_clk);
        checks++;
        if ({wbm_i_ack_o, wbm_i_err_o, wbm_d_ack_o, wbm_d_err_o} !== 4'b0000) begin
            failures++; $display("FAIL rsp_pulse_width: got %b required 0000",
                {wbm_i_ack_o, wbm_i_err_o, wbm_d_ack_o, wbm_d_err_o});
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (all_outs() !== '0) begin
            failures++; $display("FAIL reset_outputs: got %h required 0", all_outs());
        end
`ifdef YCR1_WB_ARB_TIMEOUT_EN
        checks++;
        if (timeout_o !== 1'b0) begin
            failures++; $display("FAIL reset_timeout: got %b required 0", timeout_o);
        end
`endif
    endtask

    task automatic test_dmem_write();
        int lat; bit who;
        wbm_d_stb_i = 1; wbm_d_we_i = 1; wbm_d_adr_i = 32'h0000_0100;
        wbm_d_dat_i = 32'hDEAD_BEEF; wbm_d_sel_i = 4'hF;
        do_round(0, 0, 1, 32'h1234_5678, lat, who);
        checks++;
        if (lat !== 3) begin
            failures++; $display("FAIL dmem_wr_latency: got %0d required 3", lat);
        end
        checks++;
        if ({wbm_i_dat_o, wbm_i_ack_o, wbm_i_err_o} !== '0) begin
            failures++; $display("FAIL imem_idle: got %h required 0",
                                 {wbm_i_dat_o, wbm_i_ack_o, wbm_i_err_o});
        end
    endtask

    task automatic test_arb_order();
        int lat; bit who;
        apply_reset();
        for (int p = 0; p < 4; p++) begin
            wbm_i_stb_i = 1; wbm_i_we_i = 0; wbm_i_adr_i = 32'h1000 + 32'(p * 4); wbm_i_sel_i = 4'hF;
            wbm_d_stb_i = 1; wbm_d_we_i = 0; wbm_d_adr_i = 32'h2000 + 32'(p * 4);
            wbm_d_dat_i = $urandom; wbm_d_sel_i = 4'hF;
            do_round($urandom_range(0, 2), 0, 1, $urandom, lat, who);
            checks++;
            if (who !== (ARB_MODE == 1)) begin
                failures++; $display("FAIL arb_first_pair%0d: dmem_won=%b required %b", p, who, ARB_MODE == 1);
            end
            do_round($urandom_range(0, 2), 0, 1, $urandom, lat, who);
            checks++;
            if (who !== (ARB_MODE != 1)) begin
                failures++; $display("FAIL arb_second_pair%0d: dmem_won=%b required %b", p, who, ARB_MODE != 1);
            end
        end
    endtask

    task automatic test_imem_write();
        int lat; bit who;
        wbm_i_stb_i = 1; wbm_i_we_i = 1; wbm_i_adr_i = 32'h0000_0080; wbm_i_sel_i = 4'hF;
        do_round(0, 0, 1, 32'h0, lat, who);
        wbm_i_we_i = 0;
        checks++;
        if (lat !== 1) begin
            failures++; $display("FAIL imem_wr_latency: got %0d required 1", lat);
        end
    endtask

    task automatic test_ack_err_both();
        int lat; bit who;
        wbm_d_stb_i = 1; wbm_d_we_i = 0; wbm_d_adr_i = 32'h0000_0200;
        wbm_d_dat_i = '0; wbm_d_sel_i = 4'h3;
        do_round(1, 1, 1, 32'hCAFE_F00D, lat, who);
    endtask

    task automatic test_reset_mid();
        int lat; bit who; bit seen;
        seen = 0;
        wbm_d_stb_i = 1; wbm_d_we_i = 1; wbm_d_adr_i = 32'h0000_0300;
        wbm_d_dat_i = 32'h5555_AAAA; wbm_d_sel_i = 4'hF;
        for (int n = 0; n < 6 && !seen; n++) begin
            @(negedge wb_clk);
            if (wbs_stb_o === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++; $display("FAIL rst_mid_start: wbs_stb_o never rose");
        end
        repeat (2) @(negedge wb_clk);
        wb_rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            failures++; $display("FAIL rst_mid_outputs: got %h required 0", all_outs());
        end
        wbm_d_stb_i = 0;
        repeat (2) @(negedge wb_clk);
        checks++;
        if (all_outs() !== '0) begin
            failures++; $display("FAIL rst_mid_no_ack: got %h required 0", all_outs());
        end
        wb_rst_n = 1'b1;
        last_d = 1'b1;
        @(negedge wb_clk);
        wbm_i_stb_i = 1; wbm_i_we_i = 0; wbm_i_adr_i = 32'h0000_0040; wbm_i_sel_i = 4'hF;
        do_round(0, 0, 1, 32'hA5A5_0040, lat, who);
    endtask

    task automatic test_random();
        int lat; bit who; bit serr;
        for (int r = 0; r < 40; r++) begin
            if (!wbm_i_stb_i && ($urandom_range(0, 1) == 1)) begin
                wbm_i_stb_i = 1; wbm_i_adr_i = $urandom; wbm_i_sel_i = 4'($urandom);
                wbm_i_we_i = ($urandom_range(0, 7) == 0);
            end
            if (!wbm_d_stb_i && (($urandom_range(0, 1) == 1) || !wbm_i_stb_i)) begin
                wbm_d_stb_i = 1; wbm_d_adr_i = $urandom; wbm_d_sel_i = 4'($urandom);
                wbm_d_we_i = 1'($urandom); wbm_d_dat_i = $urandom;
            end
            serr = ($urandom_range(0, 5) == 0);
            do_round($urandom_range(0, 4), serr, serr ? 1'($urandom) : 1'b1, $urandom, lat, who);
        end
        wbm_i_stb_i = 0; wbm_i_we_i = 0; wbm_d_stb_i = 0;
    endtask

`ifdef YCR1_WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int busy, lat; bit seen, who;
        busy = 0; seen = 0;
        wbm_d_stb_i = 1; wbm_d_we_i = 0; wbm_d_adr_i = 32'h0000_0400;
        wbm_d_dat_i = '0; wbm_d_sel_i = 4'hF;
        wbs_dat_i = 32'hFFFF_FFFF;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge wb_clk);
            if (wbs_stb_o === 1'b1) busy++;
            if (wbm_d_err_o === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || busy != 8) begin
            failures++; $display("FAIL timeout_cycles: err_seen=%b busy=%0d required 1/8", seen, busy);
        end
        checks++;
        if ({wbm_d_ack_o, wbm_d_dat_o, timeout_o, wbs_stb_o} !== {1'b0, 32'h0, 1'b1, 1'b0}) begin
            failures++; $display("FAIL timeout_rsp: got %h required %h",
                {wbm_d_ack_o, wbm_d_dat_o, timeout_o, wbs_stb_o}, {1'b0, 32'h0, 1'b1, 1'b0});
        end
        wbm_d_stb_i = 0;
        last_d = 1'b1;
        @(negedge wb_clk);
        wbm_d_stb_i = 1; wbm_d_adr_i = 32'h0000_0404;
        do_round(6, 0, 1, 32'h0BAD_CAFE, lat, who);
        checks++;
        if (timeout_o !== 1'b1) begin
            failures++; $display("FAIL timeout_sticky: got %b required 1", timeout_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_dmem_write();
        test_arb_order();
        test_imem_write();
        test_ack_err_both();
        test_reset_mid();
        test_random();
`ifdef YCR1_WB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ycr1_wb_mem_arb.md
Name: ycr1_wb_mem_arb

Overview:
- Two-master to one-slave Wishbone arbiter. Shares a single Wishbone memory/interconnect port between the core instruction (imem, read-only) and data (dmem) Wishbone masters of ycr1_top_wb.
- Registered request path, registered response path.
- Selectable round-robin or dmem-priority arbitration.
- Rejects illegal imem writes locally.

Parameters:
- AW, 32, address width.
- DW, 32, data width (byte-select width is DW/8).
- ARB_MODE, 0: 0 = round-robin between imem and dmem; 1 = fixed priority, dmem wins.
- TIMEOUT_CYCLES, 255: slave ack timeout in wb_clk cycles. Used only with the optional feature.

Ports:
- wb_clk  in  1  clock
- wb_rst_n  in  1  asynchronous active-low reset
- wbm_i_stb_i  in  1  imem request strobe
- wbm_i_adr_i  in  AW  imem address
- wbm_i_we_i  in  1  imem write enable (must be 0)
- wbm_i_sel_i  in  DW/8  imem byte select
- wbm_i_dat_o  out  DW  imem read data
- wbm_i_ack_o  out  1  imem ack
- wbm_i_err_o  out  1  imem error
- wbm_d_stb_i  in  1  dmem request strobe
- wbm_d_adr_i  in  AW  dmem address
- wbm_d_we_i  in  1  dmem write enable
- wbm_d_dat_i  in  DW  dmem write data
- wbm_d_sel_i  in  DW/8  dmem byte select
- wbm_d_dat_o  out  DW  dmem read data
- wbm_d_ack_o  out  1  dmem ack
- wbm_d_err_o  out  1  dmem error
- wbs_stb_o  out  1  slave strobe (also drives cyc)
- wbs_adr_o  out  AW  slave address
- wbs_we_o  out  1  slave write enable
- wbs_dat_o  out  DW  slave write data
- wbs_sel_o  out  DW/8  slave byte select
- wbs_dat_i  in  DW  slave read data
- wbs_ack_i  in  1  slave ack
- wbs_err_i  in  1  slave error

Behaviour:
- Single clock wb_clk. Reset wb_rst_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; last_grant = dmem, so imem wins the first round-robin tie.
- FSM states:
  - IDLE: sample stb inputs and select a winner.
    - None requesting: stay in IDLE.
    - Winner is imem with wbm_i_we_i=1: no slave access; go to RESP with err=1, dat=0.
    - Otherwise: latch the winner's adr/we/dat/sel into the wbs_* registers (imem dat_o = 0), set wbs_stb_o=1, record owner, go to BUSY.
  - BUSY: hold wbs_* stable.
    - On a sampled wbs_ack_i or wbs_err_i: clear wbs_stb_o at that edge, register wbs_dat_i into the owner's dat_o, raise the owner's ack_o (or err_o if wbs_err_i) for exactly one cycle, go to RESP.
    - If ack and err are both sampled high, err takes precedence and ack_o stays 0.
  - RESP: owner ack_o/err_o high this cycle only. Master strobes are ignored. Update last_grant = owner. Go to IDLE.
- Arbitration:
  - ARB_MODE=0: on simultaneous requests, grant the master that is not last_grant.
  - ARB_MODE=1: dmem always wins.
- Latency, zero-wait slave: master stb sampled at edge N, wbs_stb_o high after N+1, slave ack at N+2, master ack high during cycle N+3, next arbitration at N+4.
- Master requirement: hold stb and qualifiers until ack/err, then deassert within the RESP cycle or present a new request. A stb still high in IDLE is treated as a new request.
- The non-owner's ack/err/dat_o remain 0. dat_o holds its last value after the ack pulse.
- A master dropping stb while its transfer is in BUSY has no effect; the transfer completes.
- Reset mid-transfer: immediate return to reset values. The slave cycle is abandoned and no ack is generated.
- Only one slave transaction is ever outstanding.

Optional Feature:
- Macro YCR1_WB_ARB_TIMEOUT_EN.
- Enabled:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES with no ack/err: drop wbs_stb_o, pulse the owner's err_o one cycle via RESP, dat_o = 0.
  - A sticky output timeout_o (1 bit, reset 0) sets and is cleared only by reset.
  - An ack arriving in the same cycle the count is reached wins (normal ack).
- Disabled: no counter and no timeout_o port; BUSY waits indefinitely.

Test Plan:
- Single dmem write: adr=0x0000_0100, dat=0xDEAD_BEEF, sel=4'hF, zero-wait slave → wbs_* match exactly; wbm_d_ack_o pulses 1 cycle, 3 cycles after stb sampled; imem outputs stay 0.
- Simultaneous imem and dmem reads, ARB_MODE=0, after reset:
  - Grant order imem, dmem, imem, dmem over 4 back-to-back pairs.
  - With ARB_MODE=1, dmem is served before each pending imem request.
- Imem write attempt (we=1) → wbm_i_err_o pulses 1 cycle, wbs_stb_o never asserts.
- Slave returns wbs_err_i and wbs_ack_i together on a dmem read → wbm_d_err_o=1, wbm_d_ack_o=0.
- Slave stalls 5 cycles, reset asserted in the 3rd stall cycle → all outputs 0 immediately; after release, a new imem read at 0x0000_0040 completes normally with correct data.
- YCR1_WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks → wbm_d_err_o pulses after 8 BUSY cycles, timeout_o=1 and stays 1; the next transfer with ack at BUSY cycle 8 returns ack, not err.
